// File: rtl/axis_switch_single_slave.sv
// Registered 1-to-NMASTERS AXI-Stream router with one holding register and optional packet locking.
// Optional drop of out-of-range destinations with a dec_err pulse: define AXIS_SWITCH_SS_DECERR_EN.
module axis_switch_single_slave #(
    parameter int NMASTERS   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int HAS_ID     = 0,
    parameter int HAS_LAST   = 0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [DATA_WIDTH-1:0]          s_data_i,
    input  logic [DEST_WIDTH-1:0]          s_dest_i,
    input  logic [ID_WIDTH-1:0]            s_id_i,
    input  logic                           s_last_i,
    output logic [NMASTERS-1:0]            m_valid_o,
    input  logic [NMASTERS-1:0]            m_ready_i,
    output logic [NMASTERS*DATA_WIDTH-1:0] m_data_o,
    output logic [NMASTERS*DEST_WIDTH-1:0] m_dest_o,
    output logic [NMASTERS*ID_WIDTH-1:0]   m_id_o,
    output logic [NMASTERS-1:0]            m_last_o,
    output logic                           dec_err_o
);

`ifdef AXIS_SWITCH_SS_DECERR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PACKET = 2'd1, ST_DROP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PACKET = 2'd1} state_t;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    last_q, last_d;
    logic [DEST_WIDTH-1:0]   sel_q, sel_d;
    logic                    hvalid_q, hvalid_d;

    logic                    ready_sel;
    logic                    in_range;
    logic                    locked;
    logic                    in_drop;
    logic                    accept;
    logic [DEST_WIDTH-1:0]   route_sel;

    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (sel_q == DEST_WIDTH'(i)) ready_sel = m_ready_i[i];
        end
    end

    assign in_range = {1'b0, s_dest_i} < (DEST_WIDTH+1)'(NMASTERS);
    assign locked   = (HAS_LAST != 0) && (state_q == ST_PACKET);

`ifdef AXIS_SWITCH_SS_DECERR_EN
    assign in_drop  = (state_q == ST_DROP);
`else
    assign in_drop  = 1'b0;
`endif

    // While dropping, beats are consumed regardless of the holding register.
    assign s_ready_o = aresetn && (in_drop || !hvalid_q || ready_sel);
    assign accept    = s_valid_i && s_ready_o;

    // Out-of-range dest falls back to master 0 when it is not dropped.
    assign route_sel = locked ? sel_q : (in_range ? s_dest_i : '0);

`ifdef AXIS_SWITCH_SS_DECERR_EN
    logic dec_err_q, dec_err_d;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dest_d   = dest_q;
        id_d     = id_q;
        last_d   = last_q;
        sel_d    = sel_q;
        hvalid_d = (hvalid_q && ready_sel) ? 1'b0 : hvalid_q;
`ifdef AXIS_SWITCH_SS_DECERR_EN
        dec_err_d = 1'b0;
`endif
        if (accept) begin
`ifdef AXIS_SWITCH_SS_DECERR_EN
            if (state_q == ST_DROP) begin
                if (s_last_i) state_d = ST_IDLE;
            end else if (!in_range && !locked) begin
                dec_err_d = 1'b1;
                if ((HAS_LAST != 0) && !s_last_i) state_d = ST_DROP;
            end else
`endif
            begin
                data_d   = s_data_i;
                dest_d   = s_dest_i;
                id_d     = s_id_i;
                last_d   = s_last_i;
                sel_d    = route_sel;
                hvalid_d = 1'b1;
                if (HAS_LAST != 0) state_d = s_last_i ? ST_IDLE : ST_PACKET;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dest_q   <= '0;
            id_q     <= '0;
            last_q   <= 1'b0;
            sel_q    <= '0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
            id_q     <= id_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            hvalid_q <= hvalid_d;
        end
    end

`ifdef AXIS_SWITCH_SS_DECERR_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) dec_err_q <= 1'b0;
        else          dec_err_q <= dec_err_d;
    end
    assign dec_err_o = dec_err_q;
`else
    assign dec_err_o = 1'b0;
`endif

    always_comb begin
        m_valid_o = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            m_valid_o[i] = hvalid_q && (sel_q == DEST_WIDTH'(i));
        end
    end

    assign m_data_o = {NMASTERS{data_q}};
    assign m_dest_o = {NMASTERS{dest_q}};
    assign m_id_o   = (HAS_ID != 0)   ? {NMASTERS{id_q}}   : '0;
    assign m_last_o = (HAS_LAST != 0) ? {NMASTERS{last_q}} : '0;

endmodule

// File: tb/tb_axis_switch_single_slave.sv
// Directed bench for axis_switch_single_slave: beat routing, packet locking, stall, decode error, reset.
module tb_axis_switch_single_slave;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [1:0]    s_dest = '0;
    logic          s_id = 1'b0;
    logic          s_last = 1'b0;
    logic [2:0]    sv = '0;
    logic [3:0]    m_ready = 4'hF;

    logic          rdy0, rdy1, rdy2, de0, de1, de2;
    logic [3:0]    mv0, mv1, mlast0, mlast1, mid0, mid1;
    logic [2:0]    mv2, mlast2, mid2;
    logic [4*DW-1:0] md0, md1;
    logic [3*DW-1:0] md2;
    logic [7:0]    mdest0, mdest1;
    logic [5:0]    mdest2;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axis_switch_single_slave #(.NMASTERS(4), .DATA_WIDTH(DW), .DEST_WIDTH(2), .ID_WIDTH(1),
                               .HAS_ID(0), .HAS_LAST(0)) u_beat (
        .aclk(aclk), .aresetn(aresetn), .s_valid_i(sv[0]), .s_ready_o(rdy0),
        .s_data_i(s_data), .s_dest_i(s_dest), .s_id_i(s_id), .s_last_i(s_last),
        .m_valid_o(mv0), .m_ready_i(m_ready), .m_data_o(md0), .m_dest_o(mdest0),
        .m_id_o(mid0), .m_last_o(mlast0), .dec_err_o(de0));

    axis_switch_single_slave #(.NMASTERS(4), .DATA_WIDTH(DW), .DEST_WIDTH(2), .ID_WIDTH(1),
                               .HAS_ID(1), .HAS_LAST(1)) u_pkt (
        .aclk(aclk), .aresetn(aresetn), .s_valid_i(sv[1]), .s_ready_o(rdy1),
        .s_data_i(s_data), .s_dest_i(s_dest), .s_id_i(s_id), .s_last_i(s_last),
        .m_valid_o(mv1), .m_ready_i(m_ready), .m_data_o(md1), .m_dest_o(mdest1),
        .m_id_o(mid1), .m_last_o(mlast1), .dec_err_o(de1));

    axis_switch_single_slave #(.NMASTERS(3), .DATA_WIDTH(DW), .DEST_WIDTH(2), .ID_WIDTH(1),
                               .HAS_ID(0), .HAS_LAST(1)) u_err (
        .aclk(aclk), .aresetn(aresetn), .s_valid_i(sv[2]), .s_ready_o(rdy2),
        .s_data_i(s_data), .s_dest_i(s_dest), .s_id_i(s_id), .s_last_i(s_last),
        .m_valid_o(mv2), .m_ready_i(m_ready[2:0]), .m_data_o(md2), .m_dest_o(mdest2),
        .m_id_o(mid2), .m_last_o(mlast2), .dec_err_o(de2));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; sv = '0; m_ready = 4'hF;
        tick(); tick();
        n_vec++; if ({mv0, mv1, mv2} !== 11'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", {mv0, mv1, mv2}); end
        n_vec++; if ({rdy0, rdy1, rdy2} !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b exp 000", {rdy0, rdy1, rdy2}); end
        n_vec++; if ({de0, de1, de2} !== 3'b000) begin n_err++; $display("FAIL reset_decerr got %b exp 000", {de0, de1, de2}); end
        n_vec++; if (md1 !== '0 || mlast1 !== 4'b0 || mdest1 !== 8'h0) begin n_err++; $display("FAIL reset_payload got data %h last %b dest %h exp 0", md1, mlast1, mdest1); end
        aresetn = 1'b1;
        #1;
        n_vec++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin n_err++; $display("FAIL post_reset_ready got %b exp 111", {rdy0, rdy1, rdy2}); end
        tick();
    endtask

    task automatic test_route();
        m_ready = 4'hF; sv = 3'b001; s_last = 1'b0;
        s_dest = 2'd2; s_data = 64'h0000_0000_0000_00A1;
        #1; n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL route_ready0 got %b exp 1", rdy0); end
        tick();
        n_vec++; if (mv0 !== 4'b0100) begin n_err++; $display("FAIL route_valid0 got %b exp 0100", mv0); end
        n_vec++; if (md0[2*DW +: DW] !== 64'hA1) begin n_err++; $display("FAIL route_data0 got %h exp a1", md0[2*DW +: DW]); end
        n_vec++; if (mdest0 !== 8'hAA || mid0 !== 4'b0 || mlast0 !== 4'b0) begin n_err++; $display("FAIL route_side0 got dest %h id %b last %b exp aa 0 0", mdest0, mid0, mlast0); end
        s_dest = 2'd0; s_data = 64'hB2;
        #1; n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL route_ready1 got %b exp 1", rdy0); end
        tick();
        n_vec++; if (mv0 !== 4'b0001) begin n_err++; $display("FAIL route_valid1 got %b exp 0001", mv0); end
        n_vec++; if (md0[0 +: DW] !== 64'hB2) begin n_err++; $display("FAIL route_data1 got %h exp b2", md0[0 +: DW]); end
        s_dest = 2'd3; s_data = 64'hC3;
        #1; n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL route_ready2 got %b exp 1", rdy0); end
        tick();
        n_vec++; if (mv0 !== 4'b1000) begin n_err++; $display("FAIL route_valid2 got %b exp 1000", mv0); end
        n_vec++; if (md0 !== {4{64'hC3}}) begin n_err++; $display("FAIL route_data2 got %h exp c3 x4", md0); end
        sv = '0;
        tick();
        n_vec++; if (mv0 !== 4'b0000) begin n_err++; $display("FAIL route_idle got %b exp 0000", mv0); end
    endtask

    task automatic test_packet();
        m_ready = 4'hF; sv = 3'b010;
        s_dest = 2'd1; s_last = 1'b0; s_id = 1'b1; s_data = 64'hD0;
        tick();
        n_vec++; if (mv1 !== 4'b0010 || md1[DW +: DW] !== 64'hD0) begin n_err++; $display("FAIL pkt_beat0 got valid %b data %h exp 0010 d0", mv1, md1[DW +: DW]); end
        n_vec++; if (mlast1 !== 4'b0000 || mid1 !== 4'b1111 || mdest1 !== 8'h55) begin n_err++; $display("FAIL pkt_side0 got last %b id %b dest %h exp 0000 1111 55", mlast1, mid1, mdest1); end
        s_dest = 2'd3; s_data = 64'hD1;
        tick();
        n_vec++; if (mv1 !== 4'b0010 || md1[DW +: DW] !== 64'hD1) begin n_err++; $display("FAIL pkt_beat1 got valid %b data %h exp 0010 d1", mv1, md1[DW +: DW]); end
        n_vec++; if (mlast1 !== 4'b0000 || mdest1 !== 8'hFF) begin n_err++; $display("FAIL pkt_side1 got last %b dest %h exp 0000 ff", mlast1, mdest1); end
        s_last = 1'b1; s_data = 64'hD2;
        tick();
        n_vec++; if (mv1 !== 4'b0010 || md1[DW +: DW] !== 64'hD2) begin n_err++; $display("FAIL pkt_beat2 got valid %b data %h exp 0010 d2", mv1, md1[DW +: DW]); end
        n_vec++; if (mlast1 !== 4'b1111) begin n_err++; $display("FAIL pkt_last2 got %b exp 1111", mlast1); end
        s_data = 64'hD3; s_id = 1'b0;
        tick();
        n_vec++; if (mv1 !== 4'b1000 || md1[3*DW +: DW] !== 64'hD3) begin n_err++; $display("FAIL pkt_next got valid %b data %h exp 1000 d3", mv1, md1[3*DW +: DW]); end
        sv = '0;
        tick();
        n_vec++; if (mv1 !== 4'b0000) begin n_err++; $display("FAIL pkt_idle got %b exp 0000", mv1); end
    endtask

    task automatic test_stall();
        m_ready = 4'b1101; sv = 3'b010;
        s_dest = 2'd1; s_last = 1'b1; s_data = 64'hE4;
        tick();
        s_dest = 2'd2; s_data = 64'hF5;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %b exp 0", k, rdy1); end
            n_vec++; if (mv1 !== 4'b0010 || md1[DW +: DW] !== 64'hE4 || mlast1 !== 4'b1111) begin n_err++; $display("FAIL stall_hold[%0d] got valid %b data %h last %b exp 0010 e4 1111", k, mv1, md1[DW +: DW], mlast1); end
            tick();
        end
        m_ready = 4'hF;
        #1; n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b exp 1", rdy1); end
        tick();
        n_vec++; if (mv1 !== 4'b0100 || md1[2*DW +: DW] !== 64'hF5) begin n_err++; $display("FAIL stall_next got valid %b data %h exp 0100 f5", mv1, md1[2*DW +: DW]); end
        sv = '0;
        tick();
        n_vec++; if (mv1 !== 4'b0000) begin n_err++; $display("FAIL stall_nodup got %b exp 0000", mv1); end
    endtask

    task automatic test_decerr();
        m_ready = 4'hF; sv = 3'b100;
        s_dest = 2'd3; s_last = 1'b0; s_data = 64'h60;
        #1; n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL decerr_ready0 got %b exp 1", rdy2); end
        tick();
`ifdef AXIS_SWITCH_SS_DECERR_EN
        n_vec++; if (mv2 !== 3'b000 || de2 !== 1'b1) begin n_err++; $display("FAIL decerr_beat0 got valid %b err %b exp 000 1", mv2, de2); end
`else
        n_vec++; if (mv2 !== 3'b001 || de2 !== 1'b0 || md2[0 +: DW] !== 64'h60) begin n_err++; $display("FAIL decerr_beat0 got valid %b err %b data %h exp 001 0 60", mv2, de2, md2[0 +: DW]); end
`endif
        s_last = 1'b1; s_data = 64'h61;
        #1; n_vec++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL decerr_ready1 got %b exp 1", rdy2); end
        tick();
`ifdef AXIS_SWITCH_SS_DECERR_EN
        n_vec++; if (mv2 !== 3'b000 || de2 !== 1'b0) begin n_err++; $display("FAIL decerr_beat1 got valid %b err %b exp 000 0", mv2, de2); end
`else
        n_vec++; if (mv2 !== 3'b001 || de2 !== 1'b0 || mlast2 !== 3'b111 || md2[0 +: DW] !== 64'h61) begin n_err++; $display("FAIL decerr_beat1 got valid %b err %b last %b data %h exp 001 0 111 61", mv2, de2, mlast2, md2[0 +: DW]); end
`endif
        s_dest = 2'd2; s_data = 64'h62;
        tick();
        n_vec++; if (mv2 !== 3'b100 || de2 !== 1'b0 || md2[2*DW +: DW] !== 64'h62) begin n_err++; $display("FAIL decerr_after got valid %b err %b data %h exp 100 0 62", mv2, de2, md2[2*DW +: DW]); end
        n_vec++; if (mdest2 !== 6'b101010 || mid2 !== 3'b000) begin n_err++; $display("FAIL decerr_side got dest %b id %b exp 101010 000", mdest2, mid2); end
        sv = '0;
        tick();
        n_vec++; if (mv2 !== 3'b000 || de2 !== 1'b0) begin n_err++; $display("FAIL decerr_idle got valid %b err %b exp 000 0", mv2, de2); end
    endtask

    task automatic test_reset_mid();
        m_ready = 4'b1101; sv = 3'b010;
        s_dest = 2'd1; s_last = 1'b0; s_data = 64'h70;
        tick();
        n_vec++; if (mv1 !== 4'b0010) begin n_err++; $display("FAIL rstmid_stall got %b exp 0010", mv1); end
        sv = '0; aresetn = 1'b0;
        #1; n_vec++; if ({rdy0, rdy1, rdy2} !== 3'b000) begin n_err++; $display("FAIL rstmid_ready got %b exp 000", {rdy0, rdy1, rdy2}); end
        tick();
        n_vec++; if (mv1 !== 4'b0000) begin n_err++; $display("FAIL rstmid_valid got %b exp 0000", mv1); end
        aresetn = 1'b1; m_ready = 4'hF; sv = 3'b010;
        s_dest = 2'd2; s_last = 1'b1; s_data = 64'h71;
        tick();
        n_vec++; if (mv1 !== 4'b0100 || md1[2*DW +: DW] !== 64'h71) begin n_err++; $display("FAIL rstmid_new got valid %b data %h exp 0100 71", mv1, md1[2*DW +: DW]); end
        sv = '0;
        tick();
        n_vec++; if (mv1 !== 4'b0000) begin n_err++; $display("FAIL rstmid_idle got %b exp 0000", mv1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_route();
        test_packet();
        test_stall();
        test_decerr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axis_switch_single_slave.md
# axis_switch_single_slave

Registered 1-to-NMASTERS AXI-Stream router that steers each beat (or whole packet, when HAS_LAST) from one slave port to the master port selected by s_dest. It sits downstream of the N-to-1 stream arbiter, typically fanning a merged command stream back out to per-accelerator queues. It provides one cycle of latency, one beat per cycle of throughput, and packet locking so packets are never split across outputs.

## Interface
- NMASTERS, 2, number of master (output) ports, ≥2
- DATA_WIDTH, 64, tdata width
- DEST_WIDTH, 1, tdest width; must satisfy 2^DEST_WIDTH ≥ NMASTERS
- ID_WIDTH, 1, tid width
- HAS_ID, 0, forward s_id to m_id; else m_id driven '0
- HAS_LAST, 0, packet mode (route per packet); else every beat routed independently, m_last driven '0
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_valid / s_ready  in / out  1  slave handshake
- s_data  in  DATA_WIDTH  slave data
- s_dest  in  DEST_WIDTH  route select
- s_id  in  ID_WIDTH  slave id
- s_last  in  1  end of packet
- m_valid  out  NMASTERS  per-master valid
- m_ready  in  NMASTERS  per-master ready
- m_data  out  NMASTERS*DATA_WIDTH  holding-register data replicated to every slice
- m_dest  out  NMASTERS*DEST_WIDTH  replicated dest
- m_id  out  NMASTERS*ID_WIDTH  replicated id (or '0)
- m_last  out  NMASTERS  replicated last (or '0)
- dec_err  out  1  one-cycle pulse: out-of-range packet dropped

## Operation
- Single holding register {data, dest, id, last, sel, hvalid}. m_valid[i] = hvalid && sel==i.
- s_ready = aresetn && (!hvalid || m_ready[sel]). Beat accepted on s_valid && s_ready and loaded into holding register.
- Select decode: sel = s_dest if s_dest < NMASTERS; else out-of-range (see Configuration).
- States (HAS_LAST=1): IDLE (no packet open), PACKET (sel locked), DROP (macro only).
  - IDLE: first accepted beat decodes sel; if !s_last → PACKET, else stay IDLE.
  - PACKET: beats use locked sel, s_dest ignored; accepted beat with s_last → IDLE.
  - DROP: beats accepted (s_ready=1) and discarded, holding register untouched; accepted beat with s_last → IDLE.
- HAS_LAST=0: FSM stays IDLE; each beat decoded independently.
- Reset: hvalid=0, m_valid='0, s_ready=0, state IDLE, sel=0, dec_err=0, data/dest/id/last outputs 0.

## Timing
- Latency: beat accepted at edge t is visible on m_valid[sel] from cycle t+1.
- Throughput: 1 beat/cycle while m_ready[sel]=1, including back-to-back beats to different masters (HAS_LAST=0) or consecutive packets.
- Back-pressure: hvalid && !m_ready[sel] → s_ready=0; holding register and m_valid held stable until m_ready[sel].
- Downstream AXIS rule: m_valid never drops before handshake; payload stable while stalled.
- dec_err asserted the cycle after the first beat of a dropped packet/beat is accepted, for exactly one cycle.
- Reset mid-packet: partial packet abandoned, holding-register beat lost; first beat after reset decoded as new packet.
- Reset mid-stall: m_valid deasserts the cycle after reset sampled.

## Configuration
- AXIS_SWITCH_SS_DECERR_EN defined: out-of-range s_dest beat (HAS_LAST=0) or packet first beat (HAS_LAST=1) enters drop handling — consumed, never presented, dec_err pulsed; HAS_LAST=1 enters DROP until s_last.
- Not defined: out-of-range dest routed to master 0 as a normal beat/packet; DROP state absent; dec_err tied 0.

## Test plan
- NMASTERS=4, HAS_LAST=0, all m_ready=1: beats dest 2,0,3 on consecutive cycles → m_valid=0100,0001,1000 on cycles t+1..t+3, data in order, s_ready constant 1.
- HAS_LAST=1: 3-beat packet first dest=1, later beats dest=3 → all 3 beats on master 1, m_last only on 3rd; next packet dest=3 → master 3.
- Stall: m_ready[1]=0 for 5 cycles with beat held → m_valid[1] stable, payload stable, s_ready=0; m_ready[1]=1 → delivered once, no duplicate.
- NMASTERS=3, DEST_WIDTH=2, dest=3, 2-beat packet: with macro → 0 beats out, dec_err one 1-cycle pulse, s_ready=1; without → both beats on master 0, dec_err=0.
- Assert aresetn=0 one cycle mid-packet with stalled beat → m_valid='0 next cycle, s_ready=0 during reset; next beat dest=2 routed to master 2 as new packet.
